calc_sequencer: RTL

Controller for the keypad calculator's arithmetic path. It takes decoded key codes from the keypad decoder and builds two 4-digit BCD operands and an operator. It sequences a shared multi-cycle ALU through a start/done handshake, then holds the result for the 7-segment display path. It sits between the keypad decoder (slow clock domain) and the ALU/display, and replaces ad-hoc operand capture with one owner of operand, operator and result registers.

---
 rtl/calc_pkg.sv | 47 ++++
 rtl/calc_sequencer_key_press.sv | 33 +++
 rtl/calc_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator arithmetic path:
// key codes, ALU op encoding, sequencer states and display constants.
package calc_pkg;

    localparam int KEY_NONE_BIT = 4;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } alu_op_t;

    typedef enum logic [2:0] {
        S_ENTRY_A = 3'd0,
        S_ENTRY_B = 3'd1,
        S_RUN     = 3'd2,
        S_WAIT    = 3'd3,
        S_SHOW    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    localparam logic [15:0] BCD_BLANK = 16'hFFFF;

    function automatic logic is_digit(input logic [3:0] c);
        return c <= 4'd9;
    endfunction

    function automatic logic is_oper(input logic [3:0] c);
        return (c >= KEY_ADD) && (c <= KEY_DIV);
    endfunction

    // Operator keys 10..13 map in order onto ops 0..3.
    function automatic alu_op_t key_to_op(input logic [3:0] c);
        logic [3:0] d;
        d = c - KEY_ADD;
        return alu_op_t'(d[1:0]);
    endfunction

endpackage

// File: rtl/calc_sequencer_key_press.sv
// Key press detector: turns the level key input into a one-cycle event.
// Ports: clk, rst (async active-low), key in; ev pulse and code out.
module calc_sequencer_key_press
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key,
    output logic       ev,
    output logic [3:0] code
);

    // Remembers that the previous cycle had no key; cleared by reset
    // so a key held through reset needs a release first.
    logic idle_q;
    logic idle_d;

    always_comb begin
        idle_d = key[KEY_NONE_BIT];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_q <= 1'b0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign ev   = idle_q & ~key[KEY_NONE_BIT];
    assign code = key[3:0];

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: builds BCD operands and operator from key events,
// runs the shared ALU via start/done, holds the result for display.
// Ports: clk, rst (async active-low), key; alu_start/op/a/b, alu_done/
// result/err; st (state code), disp (BCD digits), err.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  key,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic        alu_err,
    output logic [2:0]  st,
    output logic [15:0] disp,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic       ev;
    logic [3:0] code;

    calc_sequencer_key_press u_key (
        .clk  (clk),
        .rst  (rst),
        .key  (key),
        .ev   (ev),
        .code (code)
    );

    state_t        state_q, state_d;
    logic [15:0]   a_q, a_d;
    logic [15:0]   b_q, b_d;
    logic [15:0]   r_q, r_d;
    logic [2:0]    cnt_a_q, cnt_a_d;
    logic [2:0]    cnt_b_q, cnt_b_d;
    alu_op_t       op_q, op_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          alu_start_q, alu_start_d;
    logic [15:0]   disp_q, disp_d;
    logic          err_q, err_d;

    logic k_dig, k_op, k_eq, k_clr;

    always_comb begin
        k_dig = ev && is_digit(code);
        k_op  = ev && is_oper(code);
        k_eq  = ev && (code == KEY_EQ);
        k_clr = ev && (code == KEY_CLR);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        op_d    = op_q;
        tmo_d   = tmo_q;

        // Clear beats everything, including a done arriving in WAIT.
        if (k_clr) begin
            state_d = S_ENTRY_A;
            a_d     = '0;
            b_d     = '0;
            r_d     = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            op_d    = OP_ADD;
            tmo_d   = '0;
        end else begin
            case (state_q)
                S_ENTRY_A: begin
                    unique case (1'b1)
                        k_dig: begin
                            if (cnt_a_q < 3'd4) begin
                                a_d     = {a_q[11:0], code};
                                cnt_a_d = cnt_a_q + 3'd1;
                            end
                        end
                        k_op: begin
                            op_d    = key_to_op(code);
                            b_d     = '0;
                            cnt_b_d = '0;
                            state_d = S_ENTRY_B;
                        end
                        default: ;
                    endcase
                end
                S_ENTRY_B: begin
                    unique case (1'b1)
                        k_dig: begin
                            if (cnt_b_q < 3'd4) begin
                                b_d     = {b_q[11:0], code};
                                cnt_b_d = cnt_b_q + 3'd1;
                            end
                        end
                        k_op: op_d = key_to_op(code);
                        k_eq: begin
                            if (cnt_b_q != 3'd0) begin
                                state_d = S_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
                S_RUN: begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // Done is checked before the timeout so it wins a tie.
                    if (alu_done) begin
                        if (alu_err) begin
                            state_d = S_ERR;
                        end else begin
                            r_d     = alu_result;
                            state_d = S_SHOW;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = S_ERR;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                S_SHOW: begin
                    unique case (1'b1)
                        k_dig: begin
                            a_d     = {12'h000, code};
                            cnt_a_d = 3'd1;
                            state_d = S_ENTRY_A;
                        end
                        k_op: begin
                            // Chain: the shown result becomes operand A.
                            a_d     = r_q;
                            cnt_a_d = 3'd4;
                            op_d    = key_to_op(code);
                            b_d     = '0;
                            cnt_b_d = '0;
                            state_d = S_ENTRY_B;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end

        // Registered outputs follow the next state so they line up with st.
        alu_start_d = (state_d == S_RUN);
        err_d       = (state_d == S_ERR);
        case (state_d)
            S_ENTRY_A: disp_d = a_d;
            S_ENTRY_B: disp_d = b_d;
            S_RUN:     disp_d = b_d;
            S_WAIT:    disp_d = b_d;
            S_SHOW:    disp_d = r_d;
            default:   disp_d = BCD_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_ENTRY_A;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            op_q        <= OP_ADD;
            tmo_q       <= '0;
            alu_start_q <= 1'b0;
            disp_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            op_q        <= op_d;
            tmo_q       <= tmo_d;
            alu_start_q <= alu_start_d;
            disp_q      <= disp_d;
            err_q       <= err_d;
        end
    end

    assign st        = state_q;
    assign alu_start = alu_start_q;
    assign disp      = disp_q;
    assign err       = err_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;

endmodule
